// File: rtl/clkscaler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clkscaler_pkg
// Purpose  : Shared constants and helpers for the multi-channel clock scaler:
//            mode encodings and the trigger priority encoder.
// Revision : 1.0 - initial release
// ============================================================================
package clkscaler_pkg;

    // Per-channel run mode, latched when a channel restarts
    localparam logic MODE_CONT = 1'b0;
    localparam logic MODE_SHOT = 1'b1;

    // Widest trigger vector the encoder accepts, and the width of its result
    localparam int MAX_TRIG_W = 32;
    localparam int K_W_MAX    = 5;

    // Width of a rate index for a given trigger width (never zero-width)
    function automatic int k_width(input int trig_w);
        return (trig_w > 1) ? $clog2(trig_w) : 1;
    endfunction

    // Index of the highest set bit; an all-zero vector yields 0. Callers
    // narrow the result to $clog2(TRIG_W) bits.
    function automatic logic [K_W_MAX-1:0] prio_enc(input logic [MAX_TRIG_W-1:0] vec);
        logic [K_W_MAX-1:0] k;
        k = '0;
        for (int i = 0; i < MAX_TRIG_W; i++) begin
            if (vec[i]) begin
                k = K_W_MAX'(i);
            end
        end
        return k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_clkscaler_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_clkscaler_if
// Purpose  : Control and timing bundle between a controller and the clock
//            scaler: run enable, per-channel trigger/mode in, pulses out.
// Revision : 1.0 - initial release
// ============================================================================
interface multi_clkscaler_if #(
    parameter int CH     = 2,
    parameter int TRIG_W = 6
);
    logic                   enable;
    logic [CH*TRIG_W-1:0]   trigger;
    logic [CH-1:0]          mode;
    logic [CH-1:0]          inc_clk;
    logic                   ref_clk;
    logic [CH-1:0]          busy;

    // Controller side: drives the rate selection, observes the time base
    modport master (
        output enable,
        output trigger,
        output mode,
        input  inc_clk,
        input  ref_clk,
        input  busy
    );

    // Scaler side
    modport slave (
        input  enable,
        input  trigger,
        input  mode,
        output inc_clk,
        output ref_clk,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/clkscaler_channel.sv
`default_nettype none
// ============================================================================
// Module   : clkscaler_channel
// Purpose  : One scaler channel. Registers its trigger, restarts on any
//            trigger change, and emits a one-cycle increment pulse every
//            P = BASE_DIV >> k cycles (continuous) or once (single-shot).
// Revision : 1.0 - initial release
// ============================================================================
module clkscaler_channel
    import clkscaler_pkg::*;
#(
    parameter int BASE_DIV = 12000,
    parameter int CNT_W    = 19,
    parameter int TRIG_W   = 6
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              enable,
    input  wire logic [TRIG_W-1:0] trigger,
    input  wire logic              mode,
    output logic                   inc_clk,
    output logic                   busy
);

    localparam int              K_W    = k_width(TRIG_W);
    localparam logic [CNT_W-1:0] c_base = CNT_W'(BASE_DIV);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    // Channel states: idle (trigger 0), counting, single-shot finished
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [TRIG_W-1:0] r_trig_q;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mode;
    logic [1:0]        r_state;
    logic              r_inc;

    logic [K_W-1:0]    w_k;
    logic [CNT_W-1:0]  w_shift;
    logic [CNT_W-1:0]  w_period;
    logic [CNT_W-1:0]  w_last;
    logic              w_restart;

    // Period derived from the registered trigger; saturates at one cycle
    always_comb begin
        w_k      = K_W'(prio_enc(MAX_TRIG_W'(r_trig_q)));
        w_shift  = c_base >> w_k;
        w_period = (w_shift == '0) ? c_one : w_shift;
        w_last   = w_period - c_one;
    end

    // Any difference between the live and registered trigger restarts the
    // channel, even while disabled, so a rate change is never half-applied.
    assign w_restart = (trigger != r_trig_q);

    // Trigger tracking, restart, phase counter, mode latch and pulse register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_trig_q <= '0;
            r_cnt    <= '0;
            r_mode   <= MODE_CONT;
            r_state  <= c_st_idle;
            r_inc    <= 1'b0;
        end else begin
            r_trig_q <= trigger;
            if (w_restart) begin
                // Restart beats a pulse that would fall on this edge
                r_cnt   <= '0;
                r_inc   <= 1'b0;
                r_mode  <= mode;
                r_state <= (trigger == '0) ? c_st_idle : c_st_run;
            end else if (!enable) begin
                // Frozen: phase kept, no pulses
                r_inc <= 1'b0;
            end else if (r_state == c_st_run) begin
                if (r_cnt == w_last) begin
                    r_cnt <= '0;
                    r_inc <= 1'b1;
                    if (r_mode == MODE_SHOT) begin
                        r_state <= c_st_done;
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                    r_inc <= 1'b0;
                end
            end else begin
                // Idle or single-shot already fired: counter holds
                r_inc <= 1'b0;
            end
        end
    end

    assign inc_clk = r_inc;
    assign busy    = (r_state == c_st_run);

endmodule
`default_nettype wire

// File: rtl/multi_clkscaler.sv
`default_nettype none
// ============================================================================
// Module   : multi_clkscaler
// Purpose  : Multi-channel clock scaler. Owns the shared base counter and the
//            ref_clk square wave, and instantiates one clkscaler_channel per
//            channel to produce the counter's increment pulses.
// Revision : 1.0 - initial release
// ============================================================================
module multi_clkscaler
    import clkscaler_pkg::*;
#(
    parameter int BASE_DIV = 12000,
    parameter int CNT_W    = 19,
    parameter int TRIG_W   = 6,
    parameter int CH       = 2
) (
    input  wire logic        clk,
    input  wire logic        reset,
    multi_clkscaler_if.slave bus
);

    localparam logic [CNT_W-1:0] c_base_last = CNT_W'(BASE_DIV - 1);

    logic [CNT_W-1:0] r_base_cnt;
    logic             r_ref;
    logic [CH-1:0]    w_inc;
    logic [CH-1:0]    w_busy;

    // Base counter: wraps every BASE_DIV enabled cycles and toggles ref_clk
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_base_cnt <= '0;
            r_ref      <= 1'b0;
        end else if (bus.enable) begin
            if (r_base_cnt == c_base_last) begin
                r_base_cnt <= '0;
                r_ref      <= ~r_ref;
            end else begin
                r_base_cnt <= r_base_cnt + 1'b1;
            end
        end
    end

    // Independent channels; they share only enable and the reset
    for (genvar c = 0; c < CH; c++) begin : g_ch
        clkscaler_channel #(
            .BASE_DIV (BASE_DIV),
            .CNT_W    (CNT_W),
            .TRIG_W   (TRIG_W)
        ) u_channel (
            .clk     (clk),
            .reset   (reset),
            .enable  (bus.enable),
            .trigger (bus.trigger[c*TRIG_W +: TRIG_W]),
            .mode    (bus.mode[c]),
            .inc_clk (w_inc[c]),
            .busy    (w_busy[c])
        );
    end

    assign bus.inc_clk = w_inc;
    assign bus.busy    = w_busy;
    assign bus.ref_clk = r_ref;

endmodule
`default_nettype wire

// File: tb/tb_multi_clkscaler.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_clkscaler
// Purpose  : Directed bench for multi_clkscaler (BASE_DIV=16, CNT_W=5,
//            TRIG_W=4, CH=2). Stimulus pushes the hand-computed edge numbers
//            of expected inc_clk pulses; a monitor pops them as pulses appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_clkscaler;

    localparam int BASE_DIV = 16;
    localparam int CNT_W    = 5;
    localparam int TRIG_W   = 4;
    localparam int CH       = 2;

    logic clk = 1'b0;
    logic reset;
    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   q0[$];
    int   q1[$];
    int   mon_e0;
    int   mon_e1;

    multi_clkscaler_if #(.CH(CH), .TRIG_W(TRIG_W)) bus ();

    multi_clkscaler #(
        .BASE_DIV (BASE_DIV),
        .CNT_W    (CNT_W),
        .TRIG_W   (TRIG_W),
        .CH       (CH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Edge n is the n-th rising edge; sampled on the following falling edge
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #100000;
        $display("FAIL watchdog expired at edge %0d", edge_cnt);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
        end
    endtask

    task automatic wait_to(input int e);
        while (edge_cnt < e) @(negedge clk);
    endtask

    task automatic set_trig(input int ch, input logic [TRIG_W-1:0] v);
        bus.trigger[ch*TRIG_W +: TRIG_W] = v;
    endtask

    // Expect pulses at edges base+p, base+2p, ... (count of them)
    task automatic push(input int ch, input int base, input int p, input int count);
        for (int i = 1; i <= count; i++) begin
            if (ch == 0) q0.push_back(base + p * i);
            else         q1.push_back(base + p * i);
        end
    endtask

    // Scoreboard monitor: every pulse must match the next expected edge, and
    // an expected edge passing without a pulse is a miss
    always @(negedge clk) begin
        if (bus.inc_clk[0] === 1'b1) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL pulse_ch0 unexpected pulse at edge %0d", edge_cnt);
            end else begin
                mon_e0 = q0.pop_front();
                if (mon_e0 != edge_cnt) begin
                    errors++;
                    $display("FAIL pulse_ch0 pulse at edge %0d expected edge %0d", edge_cnt, mon_e0);
                end
            end
        end else if (q0.size() > 0 && q0[0] <= edge_cnt) begin
            checks++;
            errors++;
            mon_e0 = q0.pop_front();
            $display("FAIL pulse_ch0 no pulse at edge %0d expected edge %0d", edge_cnt, mon_e0);
        end

        if (bus.inc_clk[1] === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL pulse_ch1 unexpected pulse at edge %0d", edge_cnt);
            end else begin
                mon_e1 = q1.pop_front();
                if (mon_e1 != edge_cnt) begin
                    errors++;
                    $display("FAIL pulse_ch1 pulse at edge %0d expected edge %0d", edge_cnt, mon_e1);
                end
            end
        end else if (q1.size() > 0 && q1[0] <= edge_cnt) begin
            checks++;
            errors++;
            mon_e1 = q1.pop_front();
            $display("FAIL pulse_ch1 no pulse at edge %0d expected edge %0d", edge_cnt, mon_e1);
        end
    end

    initial begin
        reset       = 1'b0;
        bus.enable  = 1'b1;
        bus.trigger = 8'hFF;
        bus.mode    = 2'b00;

        // 1: reset state, then ref_clk toggles 16 cycles after release
        wait_to(5);
        check("rst_inc", 32'(bus.inc_clk), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_ref", 32'(bus.ref_clk), 32'h0);
        reset       = 1'b1;
        bus.trigger = 8'h00;
        wait_to(20);
        check("ref_before_first", 32'(bus.ref_clk), 32'h0);
        check("idle_busy", 32'(bus.busy), 32'h0);
        wait_to(21);
        check("ref_first_toggle", 32'(bus.ref_clk), 32'h1);

        // 2: ch0 P=4 continuous, pulses at 29,33,37
        wait_to(24);
        set_trig(0, 4'b0100);
        push(0, 25, 4, 3);
        wait_to(25);
        check("busy0_rise", 32'(bus.busy[0]), 32'h1);
        wait_to(36);
        check("ref_hold_high", 32'(bus.ref_clk), 32'h1);
        wait_to(37);
        check("ref_second_toggle", 32'(bus.ref_clk), 32'h0);

        // 3: 0110 keeps P=4 but restarts; then 0001 mid-count gives P=16
        wait_to(40);
        set_trig(0, 4'b0110);
        push(0, 41, 4, 3);
        wait_to(55);
        set_trig(0, 4'b0001);
        push(0, 56, 16, 1);
        wait_to(75);
        set_trig(0, 4'b0000);
        wait_to(76);
        check("busy0_idle", 32'(bus.busy[0]), 32'h0);

        // 4: ch1 single-shot P=2, one pulse per arming
        wait_to(80);
        bus.mode[1] = 1'b1;
        set_trig(1, 4'b1000);
        push(1, 81, 2, 1);
        wait_to(81);
        check("shot_busy_rise", 32'(bus.busy[1]), 32'h1);
        wait_to(82);
        check("shot_busy_run", 32'(bus.busy[1]), 32'h1);
        wait_to(83);
        check("shot_busy_fall", 32'(bus.busy[1]), 32'h0);
        wait_to(95);
        set_trig(1, 4'b0000);
        wait_to(100);
        set_trig(1, 4'b1000);
        push(1, 101, 2, 1);
        wait_to(102);
        check("rearm_busy", 32'(bus.busy[1]), 32'h1);
        wait_to(103);
        check("rearm_busy_fall", 32'(bus.busy[1]), 32'h0);
        wait_to(110);
        set_trig(1, 4'b0000);

        // 5: pause for 10 cycles; count and ref_clk phase resume intact
        wait_to(115);
        set_trig(0, 4'b0100);
        push(0, 116, 4, 3);
        wait_to(129);
        check("ref_before_pause", 32'(bus.ref_clk), 32'h1);
        bus.enable = 1'b0;
        wait_to(135);
        check("ref_frozen", 32'(bus.ref_clk), 32'h1);
        check("busy_while_paused", 32'(bus.busy[0]), 32'h1);
        wait_to(139);
        bus.enable = 1'b1;
        // two counts were left before the pause: pulses at 142, 146, 150
        push(0, 138, 4, 3);
        wait_to(142);
        check("ref_delayed_hold", 32'(bus.ref_clk), 32'h1);
        wait_to(143);
        check("ref_delayed_toggle", 32'(bus.ref_clk), 32'h0);
        wait_to(152);
        set_trig(0, 4'b0000);

        // 6: reset mid-run with both channels continuous
        wait_to(160);
        bus.mode    = 2'b00;
        bus.trigger = {4'b1000, 4'b0100};
        push(0, 161, 4, 2);
        push(1, 161, 2, 4);
        wait_to(170);
        check("ref_before_reset", 32'(bus.ref_clk), 32'h1);
        reset = 1'b0;
        wait_to(171);
        check("mid_rst_inc", 32'(bus.inc_clk), 32'h0);
        check("mid_rst_busy", 32'(bus.busy), 32'h0);
        check("mid_rst_ref", 32'(bus.ref_clk), 32'h0);
        wait_to(173);
        bus.trigger = 8'h00;
        wait_to(175);
        reset = 1'b1;
        wait_to(185);
        check("post_rst_idle", 32'(bus.busy), 32'h0);
        wait_to(190);
        check("post_rst_ref_low", 32'(bus.ref_clk), 32'h0);
        wait_to(191);
        check("post_rst_ref_toggle", 32'(bus.ref_clk), 32'h1);
        set_trig(1, 4'b0001);
        push(1, 192, 16, 1);
        wait_to(192);
        check("post_rst_busy1", 32'(bus.busy[1]), 32'h1);
        wait_to(210);
        set_trig(1, 4'b0000);

        wait_to(215);
        check("q0_drained", 32'(q0.size()), 32'h0);
        check("q1_drained", 32'(q1.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
